// File: rtl/tacky_packer_pkg.sv
// Shared definitions for the Tacky instruction packer: opcodes, word
// field positions, filler bytes, op classification and FSM state type.
package tacky_defs;

  // Short opcodes (8-bit ops, one per half word)
  localparam logic [4:0] OPnot  = 5'b00000;
  localparam logic [4:0] OPand  = 5'b00001;
  localparam logic [4:0] OPor   = 5'b00010;
  localparam logic [4:0] OPxor  = 5'b00011;
  localparam logic [4:0] OPadd  = 5'b00100;
  localparam logic [4:0] OPsub  = 5'b00101;
  localparam logic [4:0] OPjr   = 5'b10000;  // last short opcode; always closes a word

  // Long opcodes (full 16-bit word)
  localparam logic [4:0] OPjnz8 = 5'b11001;
  localparam logic [4:0] OPjz8  = 5'b11010;
  localparam logic [4:0] OPjp8  = 5'b11011;
  localparam logic [4:0] OPcf8  = 5'b11100;
  localparam logic [4:0] OPci8  = 5'b11101;
  localparam logic [4:0] OPpre  = 5'b11110;
  localparam logic [4:0] OPsys  = 5'b11111;

  // Word field ranges: slot 1 = bits 15:8, slot 2 = bits 7:0
  localparam int OPCODE1_HI = 15;
  localparam int OPCODE1_LO = 11;
  localparam int REG1_HI    = 10;
  localparam int REG1_LO    = 8;
  localparam int IMM8_HI    = 7;
  localparam int IMM8_LO    = 0;
  localparam int OPCODE2_HI = 7;
  localparam int OPCODE2_LO = 3;
  localparam int REG2_HI    = 2;
  localparam int REG2_LO    = 0;

  // Architectural no-op halves: "or $0,$0" and "or $1,$1"
  localparam logic [7:0] FILL1 = 8'h10;
  localparam logic [7:0] FILL2 = 8'h11;

  // Most words a single accepted op can produce
  localparam int MAX_PUSH = 3;

  typedef enum logic [1:0] {
    OP_SHORT = 2'd0,
    OP_LONG  = 2'd1,
    OP_RSVD  = 2'd2
  } op_class_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } pack_state_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    if (op <= OPjr) begin
      c = OP_SHORT;
    end else if (op >= OPjnz8) begin
      c = OP_LONG;
    end else begin
      c = OP_RSVD;
    end
    return c;
  endfunction

  function automatic logic [15:0] pre_word(input logic [7:0] val);
    return {OPpre, 3'b000, val};
  endfunction

endpackage

// File: rtl/tacky_packer_word_fifo.sv
// Output word FIFO: up to three in-order pushes and one pop per cycle,
// reports its free-entry count so the packer can throttle input.
module tacky_word_fifo
  import tacky_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   push_cnt,
  input  logic [WIDTH-1:0]             push_data [0:3],
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_word,
  output logic [$clog2(DEPTH+1)-1:0]   free
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W + 2)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;

  // Pointer advance with wrap; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input logic [1:0] k);
    logic [PTR_W+1:0] s;
    s = {2'b00, p} + (PTR_W + 2)'(k);
    if (s >= DEPTH_W) begin
      s = s - DEPTH_W;
    end else begin
      s = s;
    end
    return s[PTR_W-1:0];
  endfunction

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != {CNT_W{1'b0}});
  assign out_word  = out_valid ? mem[rd_ptr] : {WIDTH{1'b0}};
  assign free      = CNT_W'(DEPTH) - count;

  // Storage, pointers and occupancy; reset discards all queued words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < MAX_PUSH; i++) begin
        if (i < int'(push_cnt)) begin
          mem[wrap_add(wr_ptr, 2'(i))] <= push_data[i];
        end
      end
      wr_ptr <= wrap_add(wr_ptr, push_cnt);
      rd_ptr <= pop ? wrap_add(rd_ptr, 2'd1) : rd_ptr;
      count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/tacky_packer.sv
// Tacky instruction packer: pairs short ops into 16-bit words, pads with
// filler halves, and inserts pre words so long immediates arrive intact.
module tacky_packer
  import tacky_defs::*;
#(
  parameter int OFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [2:0]  in_reg,
  input  logic [15:0] in_imm,
  input  logic        in_acc,
  input  logic        flush,
  input  logic        pre_inval,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic        err
);

  localparam int FREE_W = $clog2(OFIFO_DEPTH + 1);

  pack_state_t       state;
  pack_state_t       state_next;
  logic [7:0]        pend;
  logic [7:0]        pend_next;
  logic [7:0]        trk;
  logic [7:0]        trk_next;
  logic              trk_known;
  logic              trk_known_next;
  logic              err_next;
  logic              known_eff;
  logic              accept;
  logic [7:0]        in_byte;
  logic [1:0]        push_cnt;
  logic [15:0]       push_words [0:3];
  logic [FREE_W-1:0] free;

  assign in_ready  = !reset && (free >= FREE_W'(MAX_PUSH));
  assign accept    = in_valid && in_ready;
  assign in_byte   = {in_op, in_reg};
  // A same-cycle invalidate takes effect before this op's pre check.
  assign known_eff = trk_known && !pre_inval;

  // Packing decisions: words to push this cycle and next FSM/tracker state.
  always_comb begin
    state_next     = state;
    pend_next      = pend;
    trk_next       = trk;
    trk_known_next = known_eff;
    err_next       = 1'b0;
    push_cnt       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      push_words[i] = 16'h0000;
    end

    if (accept) begin
      case (op_class(in_op))
        OP_SHORT: begin
          if (in_acc) begin
            // Slot-2 byte completes the open word, or pairs with a filler.
            push_words[push_cnt] = {(state == ST_HOLD) ? pend : FILL1, in_byte};
            push_cnt   = push_cnt + 2'd1;
            state_next = ST_EMPTY;
          end else begin
            if (state == ST_HOLD) begin
              push_words[push_cnt] = {pend, FILL2};
              push_cnt = push_cnt + 2'd1;
            end else begin
              push_cnt = push_cnt;
            end
            if (in_op == OPjr) begin
              push_words[push_cnt] = {in_byte, FILL2};
              push_cnt   = push_cnt + 2'd1;
              state_next = ST_EMPTY;
            end else begin
              pend_next  = in_byte;
              state_next = ST_HOLD;
            end
          end
        end
        OP_LONG: begin
          if (state == ST_HOLD) begin
            push_words[push_cnt] = {pend, FILL2};
            push_cnt = push_cnt + 2'd1;
          end else begin
            push_cnt = push_cnt;
          end
          state_next = ST_EMPTY;
          case (in_op)
            OPpre: begin
              push_words[push_cnt] = pre_word(in_imm[7:0]);
              push_cnt       = push_cnt + 2'd1;
              trk_next       = in_imm[7:0];
              trk_known_next = 1'b1;
            end
            OPsys: begin
              push_words[push_cnt] = {OPsys, 11'b000_0000_0000};
              push_cnt = push_cnt + 2'd1;
            end
            default: begin
              // Emit pre only when the core's pre may differ from imm[15:8].
              if (!known_eff || (in_imm[15:8] != trk)) begin
                push_words[push_cnt] = pre_word(in_imm[15:8]);
                push_cnt       = push_cnt + 2'd1;
                trk_next       = in_imm[15:8];
                trk_known_next = 1'b1;
              end else begin
                trk_next = trk;
              end
              push_words[push_cnt] = {in_op, in_reg, in_imm[7:0]};
              push_cnt = push_cnt + 2'd1;
            end
          endcase
        end
        default: begin
          err_next = 1'b1;
        end
      endcase
    end else begin
      err_next = 1'b0;
    end

    // Flush closes a held slot-1 byte after the op, if a FIFO entry is left.
    if (flush && (state_next == ST_HOLD) && (free > FREE_W'(push_cnt))) begin
      push_words[push_cnt] = {pend_next, FILL2};
      push_cnt   = push_cnt + 2'd1;
      state_next = ST_EMPTY;
    end else begin
      state_next = state_next;
    end
  end

  // FSM state, held byte, pre tracker and error pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      pend      <= 8'h00;
      trk       <= 8'h00;
      trk_known <= 1'b1;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      pend      <= pend_next;
      trk       <= trk_next;
      trk_known <= trk_known_next;
      err       <= err_next;
    end
  end

  tacky_word_fifo #(
    .DEPTH (OFIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_cnt  (push_cnt),
    .push_data (push_words),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .free      (free)
  );

endmodule
